// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cla_pkg
//  Brief  : Shared constants and helpers for the pipelined carry-lookahead
//           adder/subtractor: default operand/group sizes, group count and
//           the two's-complement saturation limits for a given width.
//  Rev    : 1.0 - initial release
// ============================================================================
package cla_pkg;

   localparam int c_default_width = 16;
   localparam int c_default_group = 4;
   // Saturation limits are produced as 64-bit values and sliced by the user.
   localparam int c_max_width     = 64;

   // Number of lookahead groups across the operand; 0 flags an unusable GROUP.
   function automatic int cla_ngroups(input int width, input int group);
      if (group < 1) begin
         return 0;
      end
      return width / group;
   endfunction

   // Largest positive value representable in 'width' bits: 2^(width-1)-1.
   function automatic logic [63:0] cla_sat_max(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   // Most negative value representable in 'width' bits: -2^(width-1).
   function automatic logic [63:0] cla_sat_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module : cla_group
//  Brief  : GROUP-bit combinational carry-lookahead slice. Produces the slice
//           sum for a given carry-in plus the group generate / propagate
//           terms used by the next lookahead level.
//  Ports  : a, b  - slice operands (b already inverted for subtraction)
//           cin   - carry into the slice
//           sum   - slice sum
//           gg    - group generate (carry out when cin = 0)
//           pg    - group propagate (carry in passes straight through)
//  Rev    : 1.0 - initial release
// ============================================================================
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = c_default_group
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             gg,
   output logic             pg
);

   logic [GROUP-1:0] w_g;
   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_c;
   logic             w_gg;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Written as a recurrence; it unrolls to flat lookahead terms per bit.
   always_comb begin
      w_c    = '0;
      w_c[0] = cin;
      w_gg   = 1'b0;
      for (int i = 1; i < GROUP; i++) begin
         w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
      end
      for (int i = 0; i < GROUP; i++) begin
         w_gg = w_g[i] | (w_p[i] & w_gg);
      end
   end

   assign sum = w_p ^ w_c;
   assign gg  = w_gg;
   assign pg  = &w_p;

endmodule
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module : cla_addsub_pipe
//  Brief  : Pipelined carry-lookahead adder/subtractor. The NGROUPS lookahead
//           groups are split evenly over STAGES register stages; each stage
//           resolves its groups from the carry handed over by the previous
//           stage. Valid/ready handshake on both sides, one result per cycle.
//  Ports  : clk, rst             - clock, synchronous active-high reset
//           in_valid / in_ready  - operand handshake
//           a, b, sub            - operands; sub=1 computes a-b
//           sat                  - clamp on signed overflow (optional)
//           out_valid / out_ready- result handshake
//           sum, cout, ovfl, zero- result and flags
//  Config : define CLA_ADDSUB_SATURATE_EN to add the sat input and the
//           signed saturation of the result.
//  Rev    : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = c_default_width,
   parameter int GROUP  = c_default_group,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef CLA_ADDSUB_SATURATE_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovfl,
   output logic             zero
);

   localparam int c_ngroups = cla_ngroups(WIDTH, GROUP);
   localparam int c_gps     = (STAGES > 0) ? c_ngroups / STAGES : 1;
   localparam int c_sbits   = c_gps * GROUP;
   localparam int c_last    = STAGES - 1;

   if ((GROUP < 1) || (STAGES < 1) || (WIDTH < 1) || (WIDTH > c_max_width) ||
       ((WIDTH % GROUP) != 0) || ((c_ngroups % STAGES) != 0)) begin : g_param_check
      $error("cla_addsub_pipe: illegal parameters WIDTH=%0d GROUP=%0d STAGES=%0d",
             WIDTH, GROUP, STAGES);
   end

   // Output register set (register of the last stage)
   logic             r_out_v;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovfl;
   logic             r_zero;

   // ------------------------------------------------------------------------
   // Stage k: combinational resolution of its groups. The registers holding
   // the hand-over from stage k-1 live in stage k (g_regs); the last stage
   // feeds the output register set directly.
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int c_rin  = WIDTH - k * c_sbits;     // operand bits still unresolved
      localparam int c_done = (k + 1) * c_sbits;       // sum bits resolved after this stage

      logic [c_rin-1:0]   w_a_in;
      logic [c_rin-1:0]   w_b_in;                    // already holds the effective (inverted) B
      logic               w_c_in;
      logic               w_v_in;
      logic               w_v_out;
      logic               w_nxt_ready;
      logic               w_adv;
      logic               w_load;
      logic [c_gps:0]     w_gc;                      // [0] seed carry, [c_gps] hand-over carry
      logic [c_gps-1:0]   w_gg;
      logic [c_gps-1:0]   w_gp;
      logic [c_sbits-1:0] w_grp_sum;
      logic [c_done-1:0]  w_psum_out;
`ifdef CLA_ADDSUB_SATURATE_EN
      logic               w_sat_in;
`endif

      if (k == 0) begin : g_src
         assign w_a_in     = a;
         assign w_b_in     = b ^ {WIDTH{sub}};
         assign w_c_in     = sub;
         assign w_v_in     = in_valid;
         assign w_psum_out = w_grp_sum;
`ifdef CLA_ADDSUB_SATURATE_EN
         assign w_sat_in   = sat;
`endif
      end else begin : g_regs
         localparam int c_prev_rin = c_rin + c_sbits;

         logic                 r_v;
         logic [c_rin-1:0]     r_a;
         logic [c_rin-1:0]     r_b;
         logic                 r_c;
         logic [k*c_sbits-1:0] r_psum;
`ifdef CLA_ADDSUB_SATURATE_EN
         logic                 r_sat;
`endif

         always_ff @(posedge clk) begin
            if (rst) begin
               r_v    <= 1'b0;
               r_a    <= '0;
               r_b    <= '0;
               r_c    <= 1'b0;
               r_psum <= '0;
`ifdef CLA_ADDSUB_SATURATE_EN
               r_sat  <= 1'b0;
`endif
            end else if (g_stage[k-1].w_load) begin
               r_v <= g_stage[k-1].w_v_in;
               // Data only moves with a real transfer; bubbles leave it untouched.
               if (g_stage[k-1].w_v_in) begin
                  r_a    <= g_stage[k-1].w_a_in[c_prev_rin-1:c_sbits];
                  r_b    <= g_stage[k-1].w_b_in[c_prev_rin-1:c_sbits];
                  r_c    <= g_stage[k-1].w_gc[c_gps];
                  r_psum <= g_stage[k-1].w_psum_out;
`ifdef CLA_ADDSUB_SATURATE_EN
                  r_sat  <= g_stage[k-1].w_sat_in;
`endif
               end
            end
         end

         assign w_a_in     = r_a;
         assign w_b_in     = r_b;
         assign w_c_in     = r_c;
         assign w_v_in     = r_v;
         assign w_psum_out = {w_grp_sum, r_psum};
`ifdef CLA_ADDSUB_SATURATE_EN
         assign w_sat_in   = r_sat;
`endif
      end

      // Handshake: the register after this stage may load when it is empty or
      // its content leaves this cycle, so ready ripples back from out_ready.
      if (k == STAGES - 1) begin : g_tail
         assign w_v_out     = r_out_v;
         assign w_nxt_ready = out_ready;
      end else begin : g_body
         assign w_v_out     = g_stage[k+1].g_regs.r_v;
         assign w_nxt_ready = g_stage[k+1].w_load;
      end

      assign w_adv  = w_v_out & w_nxt_ready;
      assign w_load = ~w_v_out | w_adv;

      for (genvar j = 0; j < c_gps; j++) begin : g_grp
         cla_group #(
            .GROUP (GROUP)
         ) u_grp (
            .a   (w_a_in[j*GROUP +: GROUP]),
            .b   (w_b_in[j*GROUP +: GROUP]),
            .cin (w_gc[j]),
            .sum (w_grp_sum[j*GROUP +: GROUP]),
            .gg  (w_gg[j]),
            .pg  (w_gp[j])
         );
      end

      // Group-level lookahead seeded by the carry entering this stage.
      always_comb begin
         w_gc    = '0;
         w_gc[0] = w_c_in;
         for (int j = 0; j < c_gps; j++) begin
            w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Final stage: flags, optional clamp, output register set
   // ------------------------------------------------------------------------
   logic             w_last_load;
   logic             w_last_v_in;
   logic [WIDTH-1:0] w_raw_sum;
   logic             w_raw_cout;
   logic             w_a_msb;
   logic             w_b_msb;
   logic             w_raw_ovfl;
   logic [WIDTH-1:0] w_fin_sum;

   assign w_last_load = g_stage[c_last].w_load;
   assign w_last_v_in = g_stage[c_last].w_v_in;
   assign w_raw_sum   = g_stage[c_last].w_psum_out;
   assign w_raw_cout  = g_stage[c_last].w_gc[c_gps];
   assign w_a_msb     = g_stage[c_last].w_a_in[c_sbits-1];
   assign w_b_msb     = g_stage[c_last].w_b_in[c_sbits-1];
   assign w_raw_ovfl  = (w_a_msb == w_b_msb) && (w_raw_sum[WIDTH-1] != w_a_msb);

`ifdef CLA_ADDSUB_SATURATE_EN
   localparam logic [63:0] c_sat_max64 = cla_sat_max(WIDTH);
   localparam logic [63:0] c_sat_min64 = cla_sat_min(WIDTH);

   // On overflow both operands share a sign; that sign picks the rail.
   assign w_fin_sum = (g_stage[c_last].w_sat_in && w_raw_ovfl) ?
                      (w_a_msb ? c_sat_min64[WIDTH-1:0] : c_sat_max64[WIDTH-1:0]) :
                      w_raw_sum;
`else
   assign w_fin_sum = w_raw_sum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_v <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovfl  <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_last_load) begin
         r_out_v <= w_last_v_in;
         if (w_last_v_in) begin
            r_sum  <= w_fin_sum;
            r_cout <= w_raw_cout;
            r_ovfl <= w_raw_ovfl;
            r_zero <= (w_fin_sum == '0);
         end
      end
   end

   assign in_ready  = g_stage[0].w_load;
   assign out_valid = r_out_v;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovfl      = r_ovfl;
   assign zero      = r_zero & r_out_v;

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module : tb_cla_addsub_pipe
//  Brief  : Directed self-checking bench for cla_addsub_pipe. Three instances
//           (STAGES = 1, 2, 4) at WIDTH=16, GROUP=4. Saturation checks are
//           compiled in when CLA_ADDSUB_SATURATE_EN is defined.
//  Rev    : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // ---------------- STAGES = 1 ----------------
   logic        s1_in_valid = 1'b0, s1_in_ready, s1_sub = 1'b0, s1_out_valid, s1_out_ready = 1'b0;
   logic [15:0] s1_a = '0, s1_b = '0, s1_sum;
   logic        s1_cout, s1_ovfl, s1_zero;
   // ---------------- STAGES = 2 ----------------
   logic        s2_in_valid = 1'b0, s2_in_ready, s2_sub = 1'b0, s2_out_valid, s2_out_ready = 1'b0;
   logic [15:0] s2_a = '0, s2_b = '0, s2_sum;
   logic        s2_cout, s2_ovfl, s2_zero;
   // ---------------- STAGES = 4 ----------------
   logic        s4_in_valid = 1'b0, s4_in_ready, s4_sub = 1'b0, s4_out_valid, s4_out_ready = 1'b0;
   logic [15:0] s4_a = '0, s4_b = '0, s4_sum;
   logic        s4_cout, s4_ovfl, s4_zero;
`ifdef CLA_ADDSUB_SATURATE_EN
   logic        s1_sat = 1'b0, s2_sat = 1'b0, s4_sat = 1'b0;
`endif

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .a(s1_a), .b(s1_b), .sub(s1_sub),
`ifdef CLA_ADDSUB_SATURATE_EN
      .sat(s1_sat),
`endif
      .out_valid(s1_out_valid), .out_ready(s1_out_ready),
      .sum(s1_sum), .cout(s1_cout), .ovfl(s1_ovfl), .zero(s1_zero)
   );

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_s2 (
      .clk(clk), .rst(rst), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
      .a(s2_a), .b(s2_b), .sub(s2_sub),
`ifdef CLA_ADDSUB_SATURATE_EN
      .sat(s2_sat),
`endif
      .out_valid(s2_out_valid), .out_ready(s2_out_ready),
      .sum(s2_sum), .cout(s2_cout), .ovfl(s2_ovfl), .zero(s2_zero)
   );

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(4)) u_s4 (
      .clk(clk), .rst(rst), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
      .a(s4_a), .b(s4_b), .sub(s4_sub),
`ifdef CLA_ADDSUB_SATURATE_EN
      .sat(s4_sat),
`endif
      .out_valid(s4_out_valid), .out_ready(s4_out_ready),
      .sum(s4_sum), .cout(s4_cout), .ovfl(s4_ovfl), .zero(s4_zero)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        sat;
      logic [15:0] sum;
      logic        cout;
      logic        ovfl;
      logic        zero;
   } vec_t;

   // ------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (s4_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", s4_out_valid); end
      total++; if (s4_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h want=0000", s4_sum); end
      total++; if (s4_cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", s4_cout); end
      total++; if (s4_ovfl !== 1'b0) begin bad++; $display("FAIL reset_ovfl got=%b want=0", s4_ovfl); end
      total++; if (s4_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", s4_zero); end
      total++; if (s4_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", s4_in_ready); end
      total++; if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0) begin bad++; $display("FAIL reset_s1 got in_ready=%b out_valid=%b want 1/0", s1_in_ready, s1_out_valid); end
      total++; if (s2_in_ready !== 1'b1 || s2_out_valid !== 1'b0) begin bad++; $display("FAIL reset_s2 got in_ready=%b out_valid=%b want 1/0", s2_in_ready, s2_out_valid); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_single_stage_add;
      @(negedge clk);
      s1_a = 16'h1234; s1_b = 16'h1111; s1_sub = 1'b0; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s1_in_valid = 1'b0;
      total++; if (s1_out_valid !== 1'b1) begin bad++; $display("FAIL s1_latency got out_valid=%b want=1", s1_out_valid); end
      total++; if (s1_sum !== 16'h2345) begin bad++; $display("FAIL s1_sum got=%h want=2345", s1_sum); end
      total++; if ({s1_cout, s1_ovfl, s1_zero} !== 3'b000) begin bad++; $display("FAIL s1_flags got c/o/z=%b want=000", {s1_cout, s1_ovfl, s1_zero}); end
      @(negedge clk);
      total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL s1_drain got out_valid=%b want=0", s1_out_valid); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_two_stage_flags;
      vec_t v [6];
      int   lat;
      v[0] = '{a:16'h7FFF, b:16'h0001, sub:1'b0, sat:1'b0, sum:16'h8000, cout:1'b0, ovfl:1'b1, zero:1'b0};
      v[1] = '{a:16'h7FFF, b:16'h0001, sub:1'b1, sat:1'b0, sum:16'h7FFE, cout:1'b1, ovfl:1'b0, zero:1'b0};
      v[2] = '{a:16'h0005, b:16'h0005, sub:1'b1, sat:1'b0, sum:16'h0000, cout:1'b1, ovfl:1'b0, zero:1'b1};
      v[3] = '{a:16'h0000, b:16'h0001, sub:1'b1, sat:1'b0, sum:16'hFFFF, cout:1'b0, ovfl:1'b0, zero:1'b0};
      v[4] = '{a:16'h8000, b:16'h8000, sub:1'b0, sat:1'b0, sum:16'h0000, cout:1'b1, ovfl:1'b1, zero:1'b1};
      v[5] = '{a:16'h8000, b:16'h0001, sub:1'b1, sat:1'b0, sum:16'h7FFF, cout:1'b1, ovfl:1'b1, zero:1'b0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         s2_a = v[i].a; s2_b = v[i].b; s2_sub = v[i].sub; s2_in_valid = 1'b1; s2_out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         s2_in_valid = 1'b0;
         lat = 1;
         while (!s2_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         total++; if (lat !== 2 || s2_out_valid !== 1'b1) begin bad++; $display("FAIL s2_latency[%0d] got=%0d valid=%b want=2", i, lat, s2_out_valid); end
         total++; if (s2_sum !== v[i].sum) begin bad++; $display("FAIL s2_sum[%0d] got=%h want=%h", i, s2_sum, v[i].sum); end
         total++; if (s2_cout !== v[i].cout) begin bad++; $display("FAIL s2_cout[%0d] got=%b want=%b", i, s2_cout, v[i].cout); end
         total++; if (s2_ovfl !== v[i].ovfl) begin bad++; $display("FAIL s2_ovfl[%0d] got=%b want=%b", i, s2_ovfl, v[i].ovfl); end
         total++; if (s2_zero !== v[i].zero) begin bad++; $display("FAIL s2_zero[%0d] got=%b want=%b", i, s2_zero, v[i].zero); end
      end
      @(negedge clk);
   endtask

`ifdef CLA_ADDSUB_SATURATE_EN
   // ------------------------------------------------------------------------
   task automatic test_saturate;
      vec_t v [4];
      int   lat;
      v[0] = '{a:16'h7FFF, b:16'h0001, sub:1'b0, sat:1'b1, sum:16'h7FFF, cout:1'b0, ovfl:1'b1, zero:1'b0};
      v[1] = '{a:16'h8000, b:16'h0001, sub:1'b1, sat:1'b1, sum:16'h8000, cout:1'b1, ovfl:1'b1, zero:1'b0};
      v[2] = '{a:16'h7FFF, b:16'h0001, sub:1'b0, sat:1'b0, sum:16'h8000, cout:1'b0, ovfl:1'b1, zero:1'b0};
      v[3] = '{a:16'h8000, b:16'h0001, sub:1'b1, sat:1'b0, sum:16'h7FFF, cout:1'b1, ovfl:1'b1, zero:1'b0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s2_a = v[i].a; s2_b = v[i].b; s2_sub = v[i].sub; s2_sat = v[i].sat;
         s2_in_valid = 1'b1; s2_out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         s2_in_valid = 1'b0;
         lat = 1;
         while (!s2_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         total++; if (s2_out_valid !== 1'b1) begin bad++; $display("FAIL sat_valid[%0d] got=%b want=1", i, s2_out_valid); end
         total++; if (s2_sum !== v[i].sum) begin bad++; $display("FAIL sat_sum[%0d] got=%h want=%h", i, s2_sum, v[i].sum); end
         total++; if (s2_ovfl !== v[i].ovfl) begin bad++; $display("FAIL sat_ovfl[%0d] got=%b want=%b", i, s2_ovfl, v[i].ovfl); end
         total++; if (s2_zero !== v[i].zero) begin bad++; $display("FAIL sat_zero[%0d] got=%b want=%b", i, s2_zero, v[i].zero); end
      end
      s2_sat = 1'b0;
      @(negedge clk);
   endtask
`endif

   // ------------------------------------------------------------------------
   task automatic test_back_to_back;
      logic [15:0] ta [8];
      logic [15:0] tb [8];
      logic [15:0] te [8];
      int          in_idx   = 0;
      int          out_idx  = 0;
      int          cyc      = 0;
      logic        saw_full = 1'b0;
      logic        was_stall = 1'b0;
      logic [15:0] held_sum = '0;
      logic        xin, xout;
      ta = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'h00FF, 16'hFFFF, 16'h1234, 16'h8000};
      tb = '{16'h0001, 16'h0020, 16'h0300, 16'h7000, 16'h0001, 16'h0001, 16'h4321, 16'h8000};
      te = '{16'h0002, 16'h0030, 16'h0400, 16'h8000, 16'h0100, 16'h0000, 16'h5555, 16'h0000};
      s4_sub = 1'b0;
      while (out_idx < 8 && cyc < 60) begin
         @(negedge clk);
         s4_out_ready = !(cyc >= 6 && cyc <= 8);
         if (in_idx < 8) begin
            s4_in_valid = 1'b1; s4_a = ta[in_idx]; s4_b = tb[in_idx];
         end else begin
            s4_in_valid = 1'b0;
         end
         #1;
         if (was_stall) begin
            total++; if (s4_sum !== held_sum || s4_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_stall_hold cyc=%0d got=%h/%b want=%h/1", cyc, s4_sum, s4_out_valid, held_sum); end
         end
         if (!s4_out_ready && s4_out_valid && !s4_in_ready) saw_full = 1'b1;
         xin  = s4_in_valid && s4_in_ready;
         xout = s4_out_valid && s4_out_ready;
         if (xout) begin
            total++; if (s4_sum !== te[out_idx]) begin bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", out_idx, s4_sum, te[out_idx]); end
         end
         was_stall = s4_out_valid && !s4_out_ready;
         held_sum  = s4_sum;
         @(posedge clk);
         if (xin)  in_idx++;
         if (xout) out_idx++;
         cyc++;
      end
      s4_in_valid = 1'b0;
      total++; if (out_idx !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", out_idx); end
      total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_drop got=%b want=1", saw_full); end
      // Nothing more may come out once all eight results were taken.
      repeat (3) @(negedge clk);
      total++; if (s4_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_duplicate got out_valid=%b want=0", s4_out_valid); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_flush;
      logic seen = 1'b0;
      @(negedge clk);
      s4_out_ready = 1'b0; s4_sub = 1'b0;
      s4_in_valid = 1'b1; s4_a = 16'h0101; s4_b = 16'h0101;
      @(posedge clk);
      @(negedge clk);
      s4_a = 16'h0202; s4_b = 16'h0202;
      @(posedge clk);
      @(negedge clk);
      s4_in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (s4_out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", s4_out_valid); end
      total++; if (s4_sum !== 16'h0000) begin bad++; $display("FAIL flush_sum got=%h want=0000", s4_sum); end
      total++; if ({s4_cout, s4_ovfl, s4_zero} !== 3'b000) begin bad++; $display("FAIL flush_flags got=%b want=000", {s4_cout, s4_ovfl, s4_zero}); end
      total++; if (s4_in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", s4_in_ready); end
      s4_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (s4_out_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b want=0", seen); end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_stage_add();
      test_two_stage_flags();
`ifdef CLA_ADDSUB_SATURATE_EN
      test_saturate();
`endif
      test_back_to_back();
      test_reset_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
